// File: rtl/axi4lite_reg_bridge.sv
// AXI4-Lite slave bridging to a single-outstanding register request/acknowledge bus.
// Latency: AW+W (or AR) handshake to reg_req 1 cycle; reg_ack to BVALID/RVALID 1 cycle.
// Backpressure: one transaction in flight; READYs drop while busy and B/R hold until BREADY/RREADY.
module axi4lite_reg_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic [2:0]            AWPROT,
  input  logic [3:0]            AWCACHE,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic [3:0]            WSTRB,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic [2:0]            ARPROT,
  input  logic [3:0]            ARCACHE,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic                  reg_req,
  output logic                  reg_we,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  output logic [3:0]            reg_wstrb,
  input  logic                  reg_ack,
  input  logic                  reg_err,
  input  logic [DATA_WIDTH-1:0] reg_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REG_WAIT, S_WRESP, S_RRESP} state_t;

  state_t                state;
  logic                  live;      // low during reset and its first cycle, keeps READYs at 0
  logic                  aw_held;
  logic                  w_held;
  logic                  last_rd;   // last grant was a read
  logic                  is_wr;     // transaction in REG_WAIT is a write
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [3:0]            w_strb;
  logic [CW-1:0]         cnt;

  logic                  idle;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic                  wr_full;
  logic                  resp_err;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [3:0]            wr_strb;
  logic                  unused_ok;

  assign idle    = live && (state == S_IDLE);
  assign AWREADY = idle && !aw_held;
  assign WREADY  = idle && !w_held;
  // A read is refused while any write half is parked, or when a full write competes and reads won last time.
  assign ARREADY = idle && !aw_held && !w_held && !(AWVALID && WVALID && last_rd);

  assign aw_hs   = AWVALID && AWREADY;
  assign w_hs    = WVALID && WREADY;
  assign ar_hs   = ARVALID && ARREADY;
  assign wr_full = (aw_held || aw_hs) && (w_held || w_hs);

  // Bypass the latches when a half arrives in the same cycle the write becomes complete.
  assign wr_addr = aw_held ? aw_addr : AWADDR;
  assign wr_data = w_held ? w_data : WDATA;
  assign wr_strb = w_held ? w_strb : WSTRB;

  // Timeout is an error just like a flagged ack.
  assign resp_err = reg_ack ? reg_err : 1'b1;

  assign unused_ok = ^{AWPROT, AWCACHE, ARPROT, ARCACHE, ARADDR[1:0], wr_addr[1:0]};

  // Main FSM: capture write halves, issue one register request, collect ack or timeout, answer on B or R.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state     <= S_IDLE;
      live      <= 1'b0;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      last_rd   <= 1'b0;
      is_wr     <= 1'b0;
      aw_addr   <= '0;
      w_data    <= '0;
      w_strb    <= '0;
      cnt       <= '0;
      BRESP     <= 2'b00;
      BVALID    <= 1'b0;
      RDATA     <= '0;
      RRESP     <= 2'b00;
      RVALID    <= 1'b0;
      reg_req   <= 1'b0;
      reg_we    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wstrb <= '0;
    end else begin
      live    <= 1'b1;
      reg_req <= 1'b0;
      case (state)
        S_IDLE: begin
          if (aw_hs) begin
            aw_held <= 1'b1;
            aw_addr <= AWADDR;
          end
          if (w_hs) begin
            w_held <= 1'b1;
            w_data <= WDATA;
            w_strb <= WSTRB;
          end
          if (ar_hs) begin
            reg_req  <= 1'b1;
            reg_we   <= 1'b0;
            reg_addr <= {ARADDR[ADDR_WIDTH-1:2], 2'b00};
            last_rd  <= 1'b1;
            is_wr    <= 1'b0;
            cnt      <= '0;
            state    <= S_REG_WAIT;
          end else if (wr_full) begin
            reg_req   <= 1'b1;
            reg_we    <= 1'b1;
            reg_addr  <= {wr_addr[ADDR_WIDTH-1:2], 2'b00};
            reg_wdata <= wr_data;
            reg_wstrb <= wr_strb;
            last_rd   <= 1'b0;
            is_wr     <= 1'b1;
            cnt       <= '0;
            state     <= S_REG_WAIT;
          end
        end
        S_REG_WAIT: begin
          if (reg_ack || (cnt == CW'(TIMEOUT))) begin
            if (is_wr) begin
              BVALID <= 1'b1;
              BRESP  <= resp_err ? 2'b10 : 2'b00;
              state  <= S_WRESP;
            end else begin
              RVALID <= 1'b1;
              RRESP  <= resp_err ? 2'b10 : 2'b00;
              RDATA  <= resp_err ? '0 : reg_rdata;
              state  <= S_RRESP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WRESP: begin
          if (BREADY) begin
            BVALID  <= 1'b0;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: begin
          if (RREADY) begin
            RVALID <= 1'b0;
            state  <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi4lite_reg_bridge.sv
// Directed bench for axi4lite_reg_bridge with TIMEOUT=4.
// Every step is cycle-exact: inputs change and outputs are sampled 1-3 ns after the rising edge.
// Register-bus acks are driven by hand from each scenario task.
module tb_axi4lite_reg_bridge;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [31:0] AWADDR;
  logic [2:0]  AWPROT;
  logic [3:0]  AWCACHE;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic [2:0]  ARPROT;
  logic [3:0]  ARCACHE;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;
  logic        reg_req;
  logic        reg_we;
  logic [31:0] reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_wstrb;
  logic        reg_ack;
  logic        reg_err;
  logic [31:0] reg_rdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 ACLK = ~ACLK;

  axi4lite_reg_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(4)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWCACHE(AWCACHE), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARCACHE(ARCACHE), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_wstrb(reg_wstrb), .reg_ack(reg_ack), .reg_err(reg_err), .reg_rdata(reg_rdata)
  );

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic idle_inputs();
    AWADDR = '0; AWPROT = 3'b010; AWCACHE = 4'h3; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = '0; ARPROT = 3'b001; ARCACHE = 4'h2; ARVALID = 1'b0; RREADY = 1'b0;
    reg_ack = 1'b0; reg_err = 1'b0; reg_rdata = '0;
  endtask

  task automatic do_reset();
    ARESETN = 1'b0;
    idle_inputs();
    tick();
    tick();
    ARESETN = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    ARESETN = 1'b0;
    idle_inputs();
    tick();
    tick();
    vectors++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID, reg_req} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_handshakes: got %b want 000000", {AWREADY, WREADY, ARREADY, BVALID, RVALID, reg_req});
    end
    vectors++;
    if ({BRESP, RRESP, RDATA} !== 36'h0) begin
      miscompares++;
      $display("FAIL reset_resp: got %h want 0", {BRESP, RRESP, RDATA});
    end
    ARESETN = 1'b1;
    tick();
    vectors++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
      miscompares++;
      $display("FAIL ready_after_reset: got %b want 111", {AWREADY, WREADY, ARREADY});
    end
  endtask

  task automatic test_write_same_cycle();
    BREADY = 1'b1;
    AWVALID = 1'b1; AWADDR = 32'h10; WVALID = 1'b1; WDATA = 32'hA5A5_0001; WSTRB = 4'hF;
    #1;
    vectors++;
    if ({AWREADY, WREADY} !== 2'b11) begin
      miscompares++;
      $display("FAIL wr_same_ready: got %b want 11", {AWREADY, WREADY});
    end
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    vectors++;
    if ({reg_req, reg_we, reg_addr, reg_wdata, reg_wstrb} !== {1'b1, 1'b1, 32'h10, 32'hA5A5_0001, 4'hF}) begin
      miscompares++;
      $display("FAIL wr_same_req: got %b %b %h %h %h want 1 1 00000010 a5a50001 f",
               reg_req, reg_we, reg_addr, reg_wdata, reg_wstrb);
    end
    tick();
    vectors++;
    if ({reg_req, AWREADY} !== 2'b00) begin
      miscompares++;
      $display("FAIL wr_same_pulse: req,awready got %b want 00", {reg_req, AWREADY});
    end
    tick();
    reg_ack = 1'b1; reg_err = 1'b0;
    tick();
    reg_ack = 1'b0;
    vectors++;
    if ({BVALID, BRESP, RVALID} !== 4'b1000) begin
      miscompares++;
      $display("FAIL wr_same_bresp: bvalid,bresp,rvalid got %b want 1000", {BVALID, BRESP, RVALID});
    end
    tick();
    vectors++;
    if ({BVALID, AWREADY} !== 2'b01) begin
      miscompares++;
      $display("FAIL wr_same_done: bvalid,awready got %b want 01", {BVALID, AWREADY});
    end
  endtask

  task automatic test_write_w_first();
    BREADY = 1'b1;
    WVALID = 1'b1; WDATA = 32'h1234_5678; WSTRB = 4'h3;
    #1;
    vectors++;
    if (WREADY !== 1'b1) begin
      miscompares++;
      $display("FAIL wfirst_wready: got %b want 1", WREADY);
    end
    tick();
    WVALID = 1'b0;
    #1;
    vectors++;
    if (WREADY !== 1'b0) begin
      miscompares++;
      $display("FAIL wfirst_wready_drop: got %b want 0", WREADY);
    end
    ARVALID = 1'b1; ARADDR = 32'h40;
    #1;
    vectors++;
    if (ARREADY !== 1'b0) begin
      miscompares++;
      $display("FAIL wfirst_ar_stall: got %b want 0", ARREADY);
    end
    ARVALID = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      vectors++;
      if (reg_req !== 1'b0) begin
        miscompares++;
        $display("FAIL wfirst_no_early_req: cycle %0d got %b want 0", k, reg_req);
      end
    end
    AWVALID = 1'b1; AWADDR = 32'h13;
    tick();
    AWVALID = 1'b0;
    vectors++;
    if ({reg_req, reg_we, reg_addr, reg_wdata, reg_wstrb} !== {1'b1, 1'b1, 32'h10, 32'h1234_5678, 4'h3}) begin
      miscompares++;
      $display("FAIL wfirst_req: got %b %b %h %h %h want 1 1 00000010 12345678 3",
               reg_req, reg_we, reg_addr, reg_wdata, reg_wstrb);
    end
    tick();
    vectors++;
    if (reg_req !== 1'b0) begin
      miscompares++;
      $display("FAIL wfirst_pulse: got %b want 0", reg_req);
    end
    reg_ack = 1'b1;
    tick();
    reg_ack = 1'b0;
    vectors++;
    if ({BVALID, BRESP} !== 3'b100) begin
      miscompares++;
      $display("FAIL wfirst_bresp: got %b want 100", {BVALID, BRESP});
    end
    tick();
  endtask

  task automatic test_read_err();
    RREADY = 1'b1;
    ARVALID = 1'b1; ARADDR = 32'h20;
    #1;
    vectors++;
    if (ARREADY !== 1'b1) begin
      miscompares++;
      $display("FAIL rderr_arready: got %b want 1", ARREADY);
    end
    tick();
    ARVALID = 1'b0;
    vectors++;
    if ({reg_req, reg_we, reg_addr} !== {1'b1, 1'b0, 32'h20}) begin
      miscompares++;
      $display("FAIL rderr_req: got %b %b %h want 1 0 00000020", reg_req, reg_we, reg_addr);
    end
    reg_ack = 1'b1; reg_err = 1'b1; reg_rdata = 32'hDEAD_BEEF;
    tick();
    reg_ack = 1'b0; reg_err = 1'b0;
    vectors++;
    if ({RVALID, RRESP, RDATA, BVALID} !== {1'b1, 2'b10, 32'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL rderr_resp: rvalid %b rresp %b rdata %h bvalid %b want 1 10 00000000 0",
               RVALID, RRESP, RDATA, BVALID);
    end
    tick();
    vectors++;
    if (RVALID !== 1'b0) begin
      miscompares++;
      $display("FAIL rderr_done: got %b want 0", RVALID);
    end
  endtask

  task automatic test_read_stall();
    RREADY = 1'b0;
    ARVALID = 1'b1; ARADDR = 32'h24;
    tick();
    ARVALID = 1'b0;
    vectors++;
    if ({reg_req, reg_addr} !== {1'b1, 32'h24}) begin
      miscompares++;
      $display("FAIL rdstall_req: got %b %h want 1 00000024", reg_req, reg_addr);
    end
    tick();
    reg_ack = 1'b1; reg_rdata = 32'hCAFE_F00D;
    tick();
    reg_ack = 1'b0; reg_rdata = 32'h0BAD_0BAD;
    vectors++;
    if ({RVALID, RRESP, RDATA} !== {1'b1, 2'b00, 32'hCAFE_F00D}) begin
      miscompares++;
      $display("FAIL rdstall_resp: got %b %b %h want 1 00 cafef00d", RVALID, RRESP, RDATA);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      vectors++;
      if ({RVALID, RDATA} !== {1'b1, 32'hCAFE_F00D}) begin
        miscompares++;
        $display("FAIL rdstall_hold: cycle %0d got %b %h want 1 cafef00d", k, RVALID, RDATA);
      end
    end
    RREADY = 1'b1;
    tick();
    vectors++;
    if (RVALID !== 1'b0) begin
      miscompares++;
      $display("FAIL rdstall_done: got %b want 0", RVALID);
    end
  endtask

  task automatic test_timeout();
    BREADY = 1'b1;
    AWVALID = 1'b1; AWADDR = 32'h30; WVALID = 1'b1; WDATA = 32'h3030_3030; WSTRB = 4'hC;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    vectors++;
    if (reg_req !== 1'b1) begin
      miscompares++;
      $display("FAIL tmo_req: got %b want 1", reg_req);
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      vectors++;
      if (BVALID !== 1'b0) begin
        miscompares++;
        $display("FAIL tmo_early_bvalid: %0d cycles after req got %b want 0", k, BVALID);
      end
    end
    tick();
    vectors++;
    if ({BVALID, BRESP} !== 3'b110) begin
      miscompares++;
      $display("FAIL tmo_bresp: 5 cycles after req got %b want 110", {BVALID, BRESP});
    end
    tick();
    vectors++;
    if (BVALID !== 1'b0) begin
      miscompares++;
      $display("FAIL tmo_done: got %b want 0", BVALID);
    end
  endtask

  task automatic test_arbitration();
    do_reset();
    RREADY = 1'b1; BREADY = 1'b1;
    ARVALID = 1'b1; ARADDR = 32'h50;
    AWVALID = 1'b1; AWADDR = 32'h54; WVALID = 1'b1; WDATA = 32'h1111_2222; WSTRB = 4'hF;
    #1;
    vectors++;
    if ({ARREADY, AWREADY, WREADY} !== 3'b111) begin
      miscompares++;
      $display("FAIL arb1_ready: got %b want 111", {ARREADY, AWREADY, WREADY});
    end
    tick();
    ARVALID = 1'b0; AWVALID = 1'b0; WVALID = 1'b0;
    vectors++;
    if ({reg_req, reg_we, reg_addr} !== {1'b1, 1'b0, 32'h50}) begin
      miscompares++;
      $display("FAIL arb1_first_read: got %b %b %h want 1 0 00000050", reg_req, reg_we, reg_addr);
    end
    reg_ack = 1'b1; reg_rdata = 32'h0000_5050;
    tick();
    reg_ack = 1'b0;
    vectors++;
    if ({RVALID, RDATA} !== {1'b1, 32'h0000_5050}) begin
      miscompares++;
      $display("FAIL arb1_rdata: got %b %h want 1 00005050", RVALID, RDATA);
    end
    tick();
    ARVALID = 1'b1; ARADDR = 32'h58;
    #1;
    vectors++;
    if ({ARREADY, AWREADY, WREADY} !== 3'b000) begin
      miscompares++;
      $display("FAIL arb1_held_stall: got %b want 000", {ARREADY, AWREADY, WREADY});
    end
    ARVALID = 1'b0;
    tick();
    vectors++;
    if ({reg_req, reg_we, reg_addr, reg_wdata} !== {1'b1, 1'b1, 32'h54, 32'h1111_2222}) begin
      miscompares++;
      $display("FAIL arb1_second_write: got %b %b %h %h want 1 1 00000054 11112222",
               reg_req, reg_we, reg_addr, reg_wdata);
    end
    reg_ack = 1'b1;
    tick();
    reg_ack = 1'b0;
    vectors++;
    if ({BVALID, RVALID} !== 2'b10) begin
      miscompares++;
      $display("FAIL arb1_bvalid: bvalid,rvalid got %b want 10", {BVALID, RVALID});
    end
    tick();
    // plain read so reads hold the last grant, then compete again
    ARVALID = 1'b1; ARADDR = 32'h5C;
    tick();
    ARVALID = 1'b0;
    reg_ack = 1'b1; reg_rdata = 32'h0;
    tick();
    reg_ack = 1'b0;
    tick();
    ARVALID = 1'b1; ARADDR = 32'h60;
    AWVALID = 1'b1; AWADDR = 32'h64; WVALID = 1'b1; WDATA = 32'h6464_6464; WSTRB = 4'hF;
    #1;
    vectors++;
    if ({ARREADY, AWREADY, WREADY} !== 3'b011) begin
      miscompares++;
      $display("FAIL arb2_ready: got %b want 011", {ARREADY, AWREADY, WREADY});
    end
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    vectors++;
    if ({reg_req, reg_we, reg_addr} !== {1'b1, 1'b1, 32'h64}) begin
      miscompares++;
      $display("FAIL arb2_first_write: got %b %b %h want 1 1 00000064", reg_req, reg_we, reg_addr);
    end
    reg_ack = 1'b1;
    tick();
    reg_ack = 1'b0;
    tick();
    tick();
    ARVALID = 1'b0;
    vectors++;
    if ({reg_req, reg_we, reg_addr} !== {1'b1, 1'b0, 32'h60}) begin
      miscompares++;
      $display("FAIL arb2_second_read: got %b %b %h want 1 0 00000060", reg_req, reg_we, reg_addr);
    end
    reg_ack = 1'b1; reg_rdata = 32'h6060_6060;
    tick();
    reg_ack = 1'b0;
    tick();
  endtask

  task automatic test_mid_reset();
    RREADY = 1'b1;
    ARVALID = 1'b1; ARADDR = 32'h70;
    tick();
    ARVALID = 1'b0;
    vectors++;
    if (reg_req !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_req: got %b want 1", reg_req);
    end
    ARESETN = 1'b0;
    #1;
    vectors++;
    if ({reg_req, RVALID, BVALID, ARREADY, AWREADY, WREADY} !== 6'b0) begin
      miscompares++;
      $display("FAIL midrst_async: got %b want 000000", {reg_req, RVALID, BVALID, ARREADY, AWREADY, WREADY});
    end
    vectors++;
    if (RDATA !== 32'h0) begin
      miscompares++;
      $display("FAIL midrst_rdata: got %h want 00000000", RDATA);
    end
    tick();
    ARESETN = 1'b1;
    reg_ack = 1'b1; reg_rdata = 32'h7777_7777;
    tick();
    reg_ack = 1'b0;
    tick();
    vectors++;
    if ({RVALID, BVALID, reg_req} !== 3'b000) begin
      miscompares++;
      $display("FAIL midrst_late_ack: got %b want 000", {RVALID, BVALID, reg_req});
    end
    ARVALID = 1'b1; ARADDR = 32'h74;
    tick();
    ARVALID = 1'b0;
    vectors++;
    if ({reg_req, reg_we, reg_addr} !== {1'b1, 1'b0, 32'h74}) begin
      miscompares++;
      $display("FAIL midrst_next_req: got %b %b %h want 1 0 00000074", reg_req, reg_we, reg_addr);
    end
    reg_ack = 1'b1; reg_rdata = 32'h7474_0001;
    tick();
    reg_ack = 1'b0;
    vectors++;
    if ({RVALID, RRESP, RDATA} !== {1'b1, 2'b00, 32'h7474_0001}) begin
      miscompares++;
      $display("FAIL midrst_next_resp: got %b %b %h want 1 00 74740001", RVALID, RRESP, RDATA);
    end
    tick();
    vectors++;
    if (RVALID !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_next_done: got %b want 0", RVALID);
    end
  endtask

  initial begin
    ARESETN = 1'b0;
    idle_inputs();
    test_reset();
    test_write_same_cycle();
    test_write_w_first();
    test_read_err();
    test_read_stall();
    test_timeout();
    test_arbitration();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
